// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, operand/destination select, ALU with an
// iterative shift-add multiplier, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteREG,
  input  logic        MemToRegREG,
  input  logic        MemReadREG,
  input  logic        MemWriteREG,
  input  logic        RegDstREG,
  input  logic        ALUSrcREG,
  input  logic [2:0]  ALUOpREG,
  input  logic [31:0] ReadData1REG,
  input  logic [31:0] ReadData2REG,
  input  logic [31:0] SignExREG,
  input  logic [4:0]  In2016REG,
  input  logic [4:0]  IN1511REG,
  input  logic        Flush,
  input  logic        RegWriteWB,
  input  logic [4:0]  WriteRegWB,
  input  logic [31:0] WriteDataWB,
  output logic        Stall,
  output logic        RegWriteEXM,
  output logic        MemToRegEXM,
  output logic        MemReadEXM,
  output logic        MemWriteEXM,
  output logic [31:0] ALUResultEXM,
  output logic [31:0] WriteDataEXM,
  output logic [4:0]  WriteRegEXM
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_acc, w_acc_nxt;
  logic [XLEN-1:0]   r_mcand, w_mcand_nxt;
  logic [XLEN-1:0]   r_mplier, w_mplier_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic              r_hold_rw, w_hold_rw_nxt;
  logic              r_hold_mtr, w_hold_mtr_nxt;
  logic              r_hold_mr, w_hold_mr_nxt;
  logic              r_hold_mw, w_hold_mw_nxt;
  logic [RW-1:0]     r_hold_wr, w_hold_wr_nxt;
  logic [XLEN-1:0]   r_hold_wd, w_hold_wd_nxt;

  logic              r_rw_exm, w_rw_nxt;
  logic              r_mtr_exm, w_mtr_nxt;
  logic              r_mr_exm, w_mr_nxt;
  logic              r_mw_exm, w_mw_nxt;
  logic [XLEN-1:0]   r_res_exm, w_res_nxt;
  logic [XLEN-1:0]   r_wd_exm, w_wd_nxt;
  logic [RW-1:0]     r_wr_exm, w_wr_nxt;

  logic [RW-1:0]     w_write_reg;
  logic              w_exm_hit, w_wb_hit;
  logic [XLEN-1:0]   w_op_a, w_op_b, w_alu_b, w_alu_res;
  logic [XLEN-1:0]   w_acc_sum;

  assign RegWriteEXM  = r_rw_exm;
  assign MemToRegEXM  = r_mtr_exm;
  assign MemReadEXM   = r_mr_exm;
  assign MemWriteEXM  = r_mw_exm;
  assign ALUResultEXM = r_res_exm;
  assign WriteDataEXM = r_wd_exm;
  assign WriteRegEXM  = r_wr_exm;

  assign w_write_reg = RegDstREG ? IN1511REG : In2016REG;

  // Only rt is carried, so both hazard checks key on In2016REG; A uses them only for I-type (RegDst=0)
  assign w_exm_hit = r_rw_exm && (r_wr_exm != '0) && (r_wr_exm == In2016REG);
  assign w_wb_hit  = RegWriteWB && (WriteRegWB != '0) && (WriteRegWB == In2016REG);

  assign w_op_b = w_exm_hit ? r_res_exm : (w_wb_hit ? WriteDataWB : ReadData2REG);
  assign w_op_a = RegDstREG ? ReadData1REG
                : (w_exm_hit ? r_res_exm : (w_wb_hit ? WriteDataWB : ReadData1REG));
  assign w_alu_b = ALUSrcREG ? SignExREG : w_op_b;

  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle ALU; multiply is handled by the sequencer below
  always_comb begin
    w_alu_res = '0;
    case (ALUOpREG)
      OP_ADD:  w_alu_res = w_op_a + w_alu_b;
      OP_SUB:  w_alu_res = w_op_a - w_alu_b;
      OP_AND:  w_alu_res = w_op_a & w_alu_b;
      OP_OR:   w_alu_res = w_op_a | w_alu_b;
      OP_SLT:  w_alu_res = XLEN'($signed(w_op_a) < $signed(w_alu_b));
      OP_XOR:  w_alu_res = w_op_a ^ w_alu_b;
      OP_PASS: w_alu_res = w_alu_b;
      default: w_alu_res = '0;
    endcase
  end

  // Next-state, multiplier datapath and EX/MEM next values; bubble by default
  always_comb begin
    w_state_nxt    = r_state;
    Stall          = 1'b0;
    w_acc_nxt      = r_acc;
    w_mcand_nxt    = r_mcand;
    w_mplier_nxt   = r_mplier;
    w_cnt_nxt      = r_cnt;
    w_hold_rw_nxt  = r_hold_rw;
    w_hold_mtr_nxt = r_hold_mtr;
    w_hold_mr_nxt  = r_hold_mr;
    w_hold_mw_nxt  = r_hold_mw;
    w_hold_wr_nxt  = r_hold_wr;
    w_hold_wd_nxt  = r_hold_wd;
    w_rw_nxt       = 1'b0;
    w_mtr_nxt      = 1'b0;
    w_mr_nxt       = 1'b0;
    w_mw_nxt       = 1'b0;
    w_res_nxt      = '0;
    w_wd_nxt       = '0;
    w_wr_nxt       = '0;

    case (r_state)
      S_IDLE: begin
        if (!Flush) begin
          if (ALUOpREG == OP_MUL) begin
            Stall          = 1'b1;
            w_state_nxt    = S_BUSY;
            w_acc_nxt      = '0;
            w_mcand_nxt    = w_op_a;
            w_mplier_nxt   = w_op_b;
            w_cnt_nxt      = '0;
            w_hold_rw_nxt  = RegWriteREG;
            w_hold_mtr_nxt = MemToRegREG;
            w_hold_mr_nxt  = MemReadREG;
            w_hold_mw_nxt  = MemWriteREG;
            w_hold_wr_nxt  = w_write_reg;
            w_hold_wd_nxt  = w_op_b;
          end else begin
            w_rw_nxt  = RegWriteREG;
            w_mtr_nxt = MemToRegREG;
            w_mr_nxt  = MemReadREG;
            w_mw_nxt  = MemWriteREG;
            w_res_nxt = w_alu_res;
            w_wd_nxt  = w_op_b;
            w_wr_nxt  = w_write_reg;
          end
        end
      end
      S_BUSY: begin
        if (Flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_nxt    = w_acc_sum;
          w_mcand_nxt  = r_mcand << 1;
          w_mplier_nxt = r_mplier >> 1;
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_IDLE;
            w_rw_nxt    = r_hold_rw;
            w_mtr_nxt   = r_hold_mtr;
            w_mr_nxt    = r_hold_mr;
            w_mw_nxt    = r_hold_mw;
            w_res_nxt   = w_acc_sum;
            w_wd_nxt    = r_hold_wd;
            w_wr_nxt    = r_hold_wr;
          end else begin
            Stall = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (rst) Stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_hold_rw  <= 1'b0;
      r_hold_mtr <= 1'b0;
      r_hold_mr  <= 1'b0;
      r_hold_mw  <= 1'b0;
      r_hold_wr  <= '0;
      r_hold_wd  <= '0;
      r_rw_exm   <= 1'b0;
      r_mtr_exm  <= 1'b0;
      r_mr_exm   <= 1'b0;
      r_mw_exm   <= 1'b0;
      r_res_exm  <= '0;
      r_wd_exm   <= '0;
      r_wr_exm   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_mcand    <= w_mcand_nxt;
      r_mplier   <= w_mplier_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hold_rw  <= w_hold_rw_nxt;
      r_hold_mtr <= w_hold_mtr_nxt;
      r_hold_mr  <= w_hold_mr_nxt;
      r_hold_mw  <= w_hold_mw_nxt;
      r_hold_wr  <= w_hold_wr_nxt;
      r_hold_wd  <= w_hold_wd_nxt;
      r_rw_exm   <= w_rw_nxt;
      r_mtr_exm  <= w_mtr_nxt;
      r_mr_exm   <= w_mr_nxt;
      r_mw_exm   <= w_mw_nxt;
      r_res_exm  <= w_res_nxt;
      r_wd_exm   <= w_wd_nxt;
      r_wr_exm   <= w_wr_nxt;
    end
  end

endmodule
